irq_sb_ctrl: RTL and testbench
==============================

IRQ_SB_CTRL -- requirements
Module: irq_sb_ctrl

Interface
REQ-001 SHALL have clk_i  input  1  system clock, all state on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have addr_i  input  32  system-bus byte address.
REQ-004 SHALL have req_i  input  1  bus request.
REQ-005 SHALL have write_enable_i  input  1  1 = write, 0 = read.
REQ-006 SHALL have write_data_i  input  32  bus write data.
REQ-007 SHALL have read_data_o  output  32  registered bus read data.
REQ-008 SHALL have irq_req_i  input  16  level interrupt requests from peripherals (bit n = source n).
REQ-009 SHALL have irq_ret_o  output  16  one-hot interrupt-return pulse to the serviced source.
REQ-010 SHALL have cpu_irq_o  output  1  interrupt request to core.
REQ-011 SHALL have cpu_irq_id_o  output  4  index of source being serviced.
REQ-012 SHALL have cpu_irq_ret_i  input  1  core handler-return strobe (mret).

Function
REQ-013 Register map SHALL be: 0x00 mask (RW, bits 15:0); 0x04 pending (RO, irq_req_i & mask); 0x08 status (RO, {27'b0, busy, id[3:0]}); 0x24 soft reset (WO).
REQ-014 Mask write SHALL occur on req_i & write_enable_i & addr 0x00; bits 31:16 ignored; allowed in any state.
REQ-015 Write of exactly 32'h1 to 0x24 SHALL act as rst for one cycle; other values ignored.
REQ-016 read_data_o SHALL update one cycle after req_i & ~write_enable_i to a mapped read address (0x00/0x04/0x08), otherwise hold; unmapped read SHALL leave it unchanged.
REQ-017 FSM SHALL have states IDLE, SERVICE, ACK.
REQ-018 IDLE: if |(irq_req_i & mask) then latch winner id and go to SERVICE next edge; else stay.
REQ-019 SERVICE: cpu_irq_o = 1, cpu_irq_id_o = latched id, both stable; on cpu_irq_ret_i go to ACK.
REQ-020 ACK: irq_ret_o[id] = 1 for exactly one cycle, cpu_irq_o = 0; next state IDLE unconditionally.
REQ-021 Latency: request seen in IDLE at edge k -> cpu_irq_o high after edge k+1 (one cycle).
REQ-022 After ACK, at least one IDLE cycle SHALL precede next SERVICE, so a source clearing on return is not re-granted.
REQ-023 Source deasserting or being masked during SERVICE SHALL NOT abort service; only cpu_irq_ret_i ends it.
REQ-024 cpu_irq_ret_i in IDLE or ACK SHALL be ignored.
REQ-025 Outputs SHALL be registered; irq_ret_o all-zero outside ACK; cpu_irq_id_o holds last id in IDLE.
REQ-026 busy in status SHALL be 1 in SERVICE and ACK.

Reset
REQ-027 On rst (or soft reset): state IDLE, mask 0, id 0, cpu_irq_o 0, irq_ret_o 0, read_data_o 0, round-robin pointer 0.
REQ-028 Reset mid-SERVICE SHALL drop cpu_irq_o next edge without any irq_ret_o pulse.

Configuration
REQ-029 Macro IRQ_ROUND_ROBIN_EN defined: winner = first set masked bit at or above pointer, wrapping 15->0; pointer = id+1 (mod 16) on ACK.
REQ-030 Macro IRQ_ROUND_ROBIN_EN undefined: fixed priority, lowest set masked index wins; no pointer register.

Verification
REQ-031 mask=0x0003, irq_req_i=0x0002 -> cpu_irq_o=1 one cycle later, id=1; cpu_irq_ret_i pulse -> irq_ret_o=0x0002 one cycle, then cpu_irq_o=0.
REQ-032 mask=0xFFFF, irq_req_i=0x8001 held, two full services -> fixed: id 0 then 0; round-robin: id 0 then 15.
REQ-033 mask=0x0000, irq_req_i=0xFFFF -> cpu_irq_o stays 0; read 0x04 returns 0.
REQ-034 in SERVICE id=3, write mask=0 and drop irq_req_i -> cpu_irq_o stays 1 until cpu_irq_ret_i, irq_ret_o=0x0008.
REQ-035 in SERVICE, write 32'h1 to 0x24 -> next cycle cpu_irq_o=0, irq_ret_o=0, read 0x00 returns 0.
REQ-036 read 0x08 during SERVICE id=5 -> read_data_o=0x15 next cycle; read 0x10 -> read_data_o unchanged.

Source files
------------

// File: rtl/irq_sb_ctrl.sv
// irq_sb_ctrl: bus-mapped interrupt controller with a single-service FSM (IDLE/SERVICE/ACK).
// Define IRQ_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest masked index wins.
module irq_sb_ctrl (
   input  logic        clk_i,
   input  logic        rst,
   input  logic [31:0] addr_i,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   input  logic [15:0] irq_req_i,
   output logic [15:0] irq_ret_o,
   output logic        cpu_irq_o,
   output logic [3:0]  cpu_irq_id_o,
   input  logic        cpu_irq_ret_i
);
   typedef enum logic [1:0] {IDLE, SERVICE, ACK} state_t;
   state_t      state_q, state_d;
   logic [15:0] mask_q, mask_d;
   logic [3:0]  id_q, id_d;
   logic        cpu_irq_q, cpu_irq_d;
   logic [15:0] irq_ret_q, irq_ret_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] masked;
   logic [3:0]  base, win;
   logic        busy, soft_rst, mask_we, rd_en;
`ifdef IRQ_ROUND_ROBIN_EN
   logic [3:0]  ptr_q, ptr_d;
   assign base = ptr_q;
`else
   assign base = 4'd0;
`endif
   assign masked   = irq_req_i & mask_q;
   assign busy     = state_q != IDLE;
   assign soft_rst = req_i & write_enable_i & (addr_i == 32'h24) & (write_data_i == 32'h1);
   assign mask_we  = req_i & write_enable_i & (addr_i == 32'h0);
   assign rd_en    = req_i & ~write_enable_i & (addr_i == 32'h0 | addr_i == 32'h4 | addr_i == 32'h8);
   // pick the first masked request at or above base, wrapping 15 -> 0
   always_comb begin
      win = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (masked[base + 4'(i)]) win = base + 4'(i);
   end
   // next-state, register-file and output computation
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_we ? write_data_i[15:0] : mask_q;
      id_d      = id_q;
      cpu_irq_d = cpu_irq_q;
      irq_ret_d = 16'd0;
      rdata_d   = !rd_en ? rdata_q :
                  addr_i == 32'h0 ? {16'd0, mask_q} :
                  addr_i == 32'h4 ? {16'd0, masked} : {27'd0, busy, id_q};
`ifdef IRQ_ROUND_ROBIN_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         IDLE: if (|masked) begin
            state_d   = SERVICE;
            id_d      = win;
            cpu_irq_d = 1'b1;
         end
         SERVICE: if (cpu_irq_ret_i) begin
            state_d   = ACK;
            cpu_irq_d = 1'b0;
            irq_ret_d = 16'd1 << id_q;
         end
         ACK: begin
            state_d = IDLE;
`ifdef IRQ_ROUND_ROBIN_EN
            ptr_d   = id_q + 4'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end
   // all state, cleared by bus soft reset as well as rst
   always_ff @(posedge clk_i) begin
      if (rst | soft_rst) begin
         state_q   <= IDLE;
         mask_q    <= 16'd0;
         id_q      <= 4'd0;
         cpu_irq_q <= 1'b0;
         irq_ret_q <= 16'd0;
         rdata_q   <= 32'd0;
`ifdef IRQ_ROUND_ROBIN_EN
         ptr_q     <= 4'd0;
`endif
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         id_q      <= id_d;
         cpu_irq_q <= cpu_irq_d;
         irq_ret_q <= irq_ret_d;
         rdata_q   <= rdata_d;
`ifdef IRQ_ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end
   assign read_data_o  = rdata_q;
   assign irq_ret_o    = irq_ret_q;
   assign cpu_irq_o    = cpu_irq_q;
   assign cpu_irq_id_o = id_q;
endmodule

// File: tb/tb_irq_sb_ctrl.sv
// tb_irq_sb_ctrl: table-driven directed bench for irq_sb_ctrl plus multi-cycle arbitration/reset sequences.
module tb_irq_sb_ctrl;
   logic        clk_i = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr_i = '0;
   logic        req_i = 1'b0;
   logic        write_enable_i = 1'b0;
   logic [31:0] write_data_i = '0;
   logic [31:0] read_data_o;
   logic [15:0] irq_req_i = '0;
   logic [15:0] irq_ret_o;
   logic        cpu_irq_o;
   logic [3:0]  cpu_irq_id_o;
   logic        cpu_irq_ret_i = 1'b0;
   int          errors = 0;
   int          checks = 0;
   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [15:0] irq;
      logic        ret;
      logic        e_cpu;
      logic [3:0]  e_id;
      logic [15:0] e_ret;
      logic [31:0] e_rd;
   } vec_t;
   vec_t vq[$];
   irq_sb_ctrl dut (
      .clk_i(clk_i), .rst(rst), .addr_i(addr_i), .req_i(req_i),
      .write_enable_i(write_enable_i), .write_data_i(write_data_i),
      .read_data_o(read_data_o), .irq_req_i(irq_req_i), .irq_ret_o(irq_ret_o),
      .cpu_irq_o(cpu_irq_o), .cpu_irq_id_o(cpu_irq_id_o), .cpu_irq_ret_i(cpu_irq_ret_i)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic add(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [15:0] irq, input logic ret, input logic e_cpu, input logic [3:0] e_id,
                      input logic [15:0] e_ret, input logic [31:0] e_rd);
      vec_t v;
      v = '{req, we, addr, wd, irq, ret, e_cpu, e_id, e_ret, e_rd};
      vq.push_back(v);
   endtask
   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
      tick();
      req_i = 1'b0; write_enable_i = 1'b0;
   endtask
   task automatic serve(input string name, input logic [3:0] eid);
      int n = 0;
      while (!cpu_irq_o && n < 10) begin
         tick();
         n++;
      end
      chk({name, " grant"}, {31'd0, cpu_irq_o}, 32'd1);
      chk({name, " id"}, {28'd0, cpu_irq_id_o}, {28'd0, eid});
      cpu_irq_ret_i = 1'b1;
      tick();
      cpu_irq_ret_i = 1'b0;
      chk({name, " ret pulse"}, {16'd0, irq_ret_o}, {16'd0, 16'd1 << eid});
      chk({name, " cpu low in ack"}, {31'd0, cpu_irq_o}, 32'd0);
      tick();
      chk({name, " ret cleared"}, {16'd0, irq_ret_o}, 32'd0);
   endtask
   initial begin
      //  req we addr      wdata         irq      ret cpu id  ret      rd
      add(0, 0, 32'h00, 32'h0,         16'h0000, 0, 0, 0, 16'h0000, 32'h00);
      add(1, 1, 32'h00, 32'hABCD_0003, 16'h0002, 0, 0, 0, 16'h0000, 32'h00);
      add(0, 0, 32'h00, 32'h0,         16'h0002, 0, 1, 1, 16'h0000, 32'h00);
      add(1, 0, 32'h08, 32'h0,         16'h0002, 0, 1, 1, 16'h0000, 32'h11);
      add(0, 0, 32'h00, 32'h0,         16'h0002, 1, 0, 1, 16'h0002, 32'h11);
      add(0, 0, 32'h00, 32'h0,         16'h0000, 1, 0, 1, 16'h0000, 32'h11);
      add(1, 0, 32'h00, 32'h0,         16'h0000, 0, 0, 1, 16'h0000, 32'h03);
      add(1, 1, 32'h00, 32'h0,         16'h0000, 0, 0, 1, 16'h0000, 32'h03);
      add(1, 0, 32'h04, 32'h0,         16'hFFFF, 0, 0, 1, 16'h0000, 32'h00);
      add(0, 0, 32'h00, 32'h0,         16'hFFFF, 0, 0, 1, 16'h0000, 32'h00);
      add(1, 1, 32'h00, 32'h0008,      16'h0008, 0, 0, 1, 16'h0000, 32'h00);
      add(1, 0, 32'h04, 32'h0,         16'h0008, 0, 1, 3, 16'h0000, 32'h08);
      add(1, 1, 32'h00, 32'h0,         16'h0000, 0, 1, 3, 16'h0000, 32'h08);
      add(0, 0, 32'h00, 32'h0,         16'h0000, 0, 1, 3, 16'h0000, 32'h08);
      add(0, 0, 32'h00, 32'h0,         16'h0000, 1, 0, 3, 16'h0008, 32'h08);
      add(0, 0, 32'h00, 32'h0,         16'h0000, 0, 0, 3, 16'h0000, 32'h08);
      add(1, 1, 32'h00, 32'h0020,      16'h0020, 0, 0, 3, 16'h0000, 32'h08);
      add(0, 0, 32'h00, 32'h0,         16'h0020, 0, 1, 5, 16'h0000, 32'h08);
      add(1, 0, 32'h08, 32'h0,         16'h0020, 0, 1, 5, 16'h0000, 32'h15);
      add(1, 0, 32'h10, 32'h0,         16'h0020, 0, 1, 5, 16'h0000, 32'h15);
      add(1, 1, 32'h24, 32'h2,         16'h0020, 0, 1, 5, 16'h0000, 32'h15);
      add(1, 0, 32'h00, 32'h0,         16'h0020, 0, 1, 5, 16'h0000, 32'h20);
      add(1, 1, 32'h24, 32'h1,         16'h0020, 0, 0, 0, 16'h0000, 32'h00);
      add(1, 0, 32'h00, 32'h0,         16'h0020, 0, 0, 0, 16'h0000, 32'h00);
      add(0, 0, 32'h00, 32'h0,         16'h0020, 1, 0, 0, 16'h0000, 32'h00);
      repeat (2) tick();
      chk("reset cpu_irq", {31'd0, cpu_irq_o}, 32'd0);
      chk("reset id", {28'd0, cpu_irq_id_o}, 32'd0);
      chk("reset irq_ret", {16'd0, irq_ret_o}, 32'd0);
      chk("reset rdata", read_data_o, 32'd0);
      rst = 1'b0;
      foreach (vq[i]) begin
         req_i = vq[i].req; write_enable_i = vq[i].we; addr_i = vq[i].addr;
         write_data_i = vq[i].wd; irq_req_i = vq[i].irq; cpu_irq_ret_i = vq[i].ret;
         tick();
         chk($sformatf("vec%0d cpu_irq", i), {31'd0, cpu_irq_o}, {31'd0, vq[i].e_cpu});
         chk($sformatf("vec%0d id", i), {28'd0, cpu_irq_id_o}, {28'd0, vq[i].e_id});
         chk($sformatf("vec%0d irq_ret", i), {16'd0, irq_ret_o}, {16'd0, vq[i].e_ret});
         chk($sformatf("vec%0d rdata", i), read_data_o, vq[i].e_rd);
      end
      req_i = 1'b0; write_enable_i = 1'b0; cpu_irq_ret_i = 1'b0;
      irq_req_i = 16'h8001;
      bus_write(32'h00, 32'hFFFF);
      serve("arb1", 4'd0);
`ifdef IRQ_ROUND_ROBIN_EN
      serve("arb2", 4'd15);
`else
      serve("arb2", 4'd0);
`endif
      serve("arb3", 4'd0);
      bus_write(32'h24, 32'h1);
      irq_req_i = 16'h00A0;
      bus_write(32'h00, 32'hFFFF);
      serve("low5", 4'd5);
      tick();
      chk("mid-service grant", {31'd0, cpu_irq_o}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("hard rst cpu_irq", {31'd0, cpu_irq_o}, 32'd0);
      chk("hard rst irq_ret", {16'd0, irq_ret_o}, 32'd0);
      chk("hard rst id", {28'd0, cpu_irq_id_o}, 32'd0);
      tick();
      chk("post rst no ret", {16'd0, irq_ret_o}, 32'd0);
      chk("post rst no grant", {31'd0, cpu_irq_o}, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
